// File: rtl/mux_arbiter_pkg.sv
// mux_arb_pkg: shared widths, park code and FSM state type for mux_arbiter
package mux_arb_pkg;
  localparam int N_REQ = 7;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_PARK = 3'b111;
  localparam int HOLD_W = 4;
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/mux_arbiter_if.sv
// mux_arbiter_if: arbiter bus; master=arbiter (req_in in; grant_out/sel_out/en_out/hold_cnt_out out), slave=requester side
interface mux_arbiter_if;
  import mux_arb_pkg::*;
  logic [N_REQ-1:0] req_in;
  logic [N_REQ-1:0] grant_out;
  logic [SEL_W-1:0] sel_out;
  logic en_out;
  logic [HOLD_W-1:0] hold_cnt_out;
  modport master(input req_in, output grant_out, sel_out, en_out, hold_cnt_out);
  modport slave(output req_in, input grant_out, sel_out, en_out, hold_cnt_out);
endinterface

// File: rtl/mux_arbiter_rr_pick.sv
// rr_pick: first set bit of mask searching upward from start, wrapping 6->0; ports mask, start in; valid, idx out
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] start,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);
  logic [SEL_W-1:0] j;
  always_comb begin
    valid = 1'b0;
    idx = '0;
    j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = SEL_W'((int'(start) + k) % N_REQ);
      if (mask[j]) begin
        valid = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin 7-way selector arbiter with bounded hold; ports clk, rst_n, bus (mux_arbiter_if.master)
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input logic clk,
  input logic rst_n,
  mux_arbiter_if.master bus
);
  state_t state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d, sel_q, sel_d, start, nxt, pick_idx;
  logic [N_REQ-1:0] grant_q, grant_d, mask;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic en_q, en_d, pick_v, sat, rel;
  assign nxt = sel_q == SEL_W'(N_REQ - 1) ? '0 : sel_q + 1'b1;
  // masking the owner is harmless on release (its bit is already 0) and required on expiry
  assign start = state_q == IDLE ? ptr_q : nxt;
  assign mask = state_q == IDLE ? bus.req_in : bus.req_in & ~grant_q;
  assign rel = ~|(bus.req_in & grant_q);
  assign sat = hold_q == HOLD_W'(MAX_HOLD);
  rr_pick u_pick (.mask(mask), .start(start), .valid(pick_v), .idx(pick_idx));
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    sel_d = sel_q;
    en_d = en_q;
    hold_d = hold_q;
    if (state_q == IDLE || rel || (sat && pick_v)) begin
      ptr_d = state_q == GRANT ? nxt : ptr_q;
      state_d = pick_v ? GRANT : IDLE;
      grant_d = pick_v ? N_REQ'(1) << pick_idx : '0;
      sel_d = pick_v ? pick_idx : SEL_PARK;
      en_d = pick_v;
      hold_d = pick_v ? HOLD_W'(1) : '0;
    end else begin
      hold_d = sat ? hold_q : hold_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_q <= '0;
      sel_q <= SEL_PARK;
      en_q <= 1'b0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      sel_q <= sel_d;
      en_q <= en_d;
      hold_q <= hold_d;
    end
  end
  assign bus.grant_out = grant_q;
  assign bus.sel_out = sel_q;
  assign bus.en_out = en_q;
  assign bus.hold_cnt_out = hold_q;
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_en: assert property (@(posedge clk) disable iff (!rst_n) en_q == |grant_q);
  a_sel: assert property (@(posedge clk) disable iff (!rst_n) en_q |-> grant_q == N_REQ'(1) << sel_q);
  a_park: assert property (@(posedge clk) disable iff (!rst_n) en_q |-> sel_q != SEL_PARK);
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed and random checks of mux_arbiter against a behavioural round-robin model
module tb_mux_arbiter;
  localparam int MH = 4;
  typedef struct {
    int owner;
    int hold;
    int ptr;
  } mdl_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  bit starve_on = 1'b0;
  int waitc[7];
  mdl_t m = '{owner: -1, hold: 0, ptr: 0};
  mux_arbiter_if bus ();
  mux_arbiter #(.MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic int pick(logic [6:0] r, int s);
    for (int k = 0; k < 7; k++) begin
      int i = (s + k) % 7;
      if (((r >> i) & 7'd1) != 0) return i;
    end
    return -1;
  endfunction
  function automatic mdl_t step(mdl_t c, logic [6:0] r);
    mdl_t n = c;
    int w;
    logic [6:0] others;
    if (c.owner < 0) begin
      w = pick(r, c.ptr);
      if (w >= 0) begin
        n.owner = w;
        n.hold = 1;
      end
    end else begin
      others = r & ~(7'd1 << c.owner);
      if (((r >> c.owner) & 7'd1) == 0 || (c.hold == MH && others != 0)) begin
        n.ptr = (c.owner + 1) % 7;
        w = pick(others, n.ptr);
        n.owner = w;
        n.hold = w >= 0 ? 1 : 0;
      end else if (c.hold < MH) n.hold = c.hold + 1;
    end
    return n;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{owner: -1, hold: 0, ptr: 0};
    else m <= step(m, bus.req_in);
  end
  task automatic check(string nm, logic [14:0] act, logic [14:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t: {grant,sel,en,hold} got %h expected %h", nm, $time, act, exp);
  endtask
  function automatic logic [14:0] outs();
    return {bus.grant_out, bus.sel_out, bus.en_out, bus.hold_cnt_out};
  endfunction
  always @(negedge clk) begin
    logic [6:0] eg;
    logic [2:0] es;
    int mx;
    eg = m.owner < 0 ? 7'd0 : 7'd1 << m.owner;
    es = m.owner < 0 ? 3'd7 : 3'(m.owner);
    check("model", outs(), {eg, es, m.owner >= 0, 4'(m.hold)});
    if (starve_on) begin
      mx = 0;
      for (int i = 0; i < 7; i++) begin
        waitc[i] = (bus.req_in[i] && !bus.grant_out[i]) ? waitc[i] + 1 : 0;
        if (waitc[i] > mx) mx = waitc[i];
      end
      n_chk++;
      if (mx <= 6 * MH) n_pass++;
      else $display("FAIL starve t=%0t: wait %0d exceeds %0d", $time, mx, 6 * MH);
    end
  end
  task automatic drive(input logic [6:0] v);
    @(negedge clk);
    #1 bus.req_in = v;
  endtask
  task automatic lit(string nm, logic [6:0] g, logic [2:0] s, logic e, logic [3:0] h);
    @(negedge clk);
    check(nm, outs(), {g, s, e, h});
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    bus.req_in = '0;
    lit("reset", 7'd0, 3'd7, 1'b0, 4'd0);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    logic [6:0] r;
    bus.req_in = '0;
    for (int i = 0; i < 7; i++) waitc[i] = 0;
    lit("reset0", 7'd0, 3'd7, 1'b0, 4'd0);
    #1 rst_n = 1'b1;
    drive(7'b0000100);
    lit("first_grant", 7'b0000100, 3'd2, 1'b1, 4'd1);
    drive(7'b0000000);
    lit("drop_idle", 7'd0, 3'd7, 1'b0, 4'd0);
    do_reset();
    drive(7'b1111111);
    for (int k = 0; k < 32; k++)
      lit("rotate", 7'd1 << ((k / 4) % 7), 3'((k / 4) % 7), 1'b1, 4'(k % 4 + 1));
    do_reset();
    drive(7'b1000000);
    lit("own6", 7'b1000000, 3'd6, 1'b1, 4'd1);
    drive(7'b0000001);
    lit("wrap0", 7'b0000001, 3'd0, 1'b1, 4'd1);
    drive(7'b0001000);
    lit("own3", 7'b0001000, 3'd3, 1'b1, 4'd1);
    for (int k = 1; k < 10; k++)
      lit("sat3", 7'b0001000, 3'd3, 1'b1, 4'(k + 1 > MH ? MH : k + 1));
    drive(7'b0101000);
    lit("expire5", 7'b0100000, 3'd5, 1'b1, 4'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_rst", outs(), {7'd0, 3'd7, 1'b0, 4'd0});
    bus.req_in = 7'b1000010;
    @(negedge clk);
    #1 rst_n = 1'b1;
    lit("post_rst", 7'b0000010, 3'd1, 1'b1, 4'd1);
    starve_on = 1'b1;
    r = '0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) r = 7'($urandom);
      drive(r);
    end
    @(negedge clk);
    starve_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
